// File: rtl/spi_flash_seq_pkg.sv
// Shared definitions for the SPI flash command sequencer. The command codes are also
// used by the flash controller and its bench.
package spi_flash_seq_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE      = 3'b000,
    CMD_WRITE_CMD = 3'b001,
    CMD_RD_STATUS = 3'b010,
    CMD_WR_DATA   = 3'b011,
    CMD_RD_DATA   = 3'b100
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WREN    = 4'd1,
    S_CHK_WEL = 4'd2,
    S_PROG    = 4'd3,
    S_POLL    = 4'd4,
    S_READ    = 4'd5,
    S_GAP     = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_e;

  localparam int STATUS_WIP_BIT = 0;
  localparam int STATUS_WEL_BIT = 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_WEL     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Command issued on entry to a state; CMD_IDLE marks a state that issues nothing.
  function automatic cmd_e state_cmd(input state_e s);
    case (s)
      S_WREN:    return CMD_WRITE_CMD;
      S_CHK_WEL: return CMD_RD_STATUS;
      S_PROG:    return CMD_WR_DATA;
      S_POLL:    return CMD_RD_STATUS;
      S_READ:    return CMD_RD_DATA;
      default:   return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_seq_cmd_issue.sv
// Command handshake towards the flash controller: holds controll/enable until ctrl_done,
// then times the idle gap and returns a one-cycle cmd_ack when the gap has elapsed.
module spi_flash_seq_cmd_issue
  import spi_flash_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       issue_i,
  input  logic [2:0] code_i,
  input  logic       ctrl_done_i,
  output logic [2:0] controll_o,
  output logic       enable_o,
  output logic       cmd_done_o,
  output logic       cmd_ack_o
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [2:0]    ctrl_q, ctrl_d;
  logic          en_q, en_d;
  logic          gap_q, gap_d;
  logic [GW-1:0] cnt_q, cnt_d;

  assign cmd_done_o = en_q & ctrl_done_i;
  assign cmd_ack_o  = gap_q & (cnt_q == '0);
  assign controll_o = ctrl_q;
  assign enable_o   = en_q;

  always_comb begin
    ctrl_d = ctrl_q;
    en_d   = en_q;
    gap_d  = gap_q;
    cnt_d  = cnt_q;
    if (gap_q) begin
      if (cnt_q == '0) gap_d = 1'b0;
      else             cnt_d = cnt_q - GW'(1);
    end
    if (cmd_done_o) begin
      ctrl_d = CMD_IDLE;
      en_d   = 1'b0;
      gap_d  = 1'b1;
      cnt_d  = GAP_LOAD;
    end
    // A new command is only requested on an idle interface (start in idle, or gap expiry).
    if (issue_i) begin
      ctrl_d = code_i;
      en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= CMD_IDLE;
      en_q   <= 1'b0;
      gap_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      en_q   <= en_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_seq.sv
// Sequencer turning a PROGRAM/READ start into the flash controller command chain,
// with bounded WEL and WIP polling and a done/err report to system control.
module spi_flash_seq
  import spi_flash_seq_pkg::*;
#(
  parameter int POLL_MAX   = 20000,
  parameter int WEL_RETRY  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  output logic [2:0] controll,
  output logic       enable,
  input  logic       ctrl_done,
  input  logic [7:0] ctrl_status,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int WW = $clog2(WEL_RETRY + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [WW-1:0] WEL_LIMIT  = WW'(WEL_RETRY);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  state_e        state_q, state_d;
  state_e        next_q, next_d;
  logic [WW-1:0] wel_cnt_q, wel_cnt_d, wel_inc;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d, poll_inc;
  logic [1:0]    err_code_q, err_code_d;
  logic          issue;
  cmd_e          issue_code;
  logic          cmd_done, cmd_ack;
  logic          status_unused;

  assign status_unused = ^ctrl_status[7:2];

  assign wel_inc  = (wel_cnt_q < WEL_LIMIT) ? wel_cnt_q + WW'(1) : wel_cnt_q;
  assign poll_inc = (poll_cnt_q < POLL_LIMIT) ? poll_cnt_q + PW'(1) : poll_cnt_q;

  spi_flash_seq_cmd_issue #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_cmd_issue (
    .clk_i      (clk),
    .rst_ni     (rst),
    .issue_i    (issue),
    .code_i     (issue_code),
    .ctrl_done_i(ctrl_done),
    .controll_o (controll),
    .enable_o   (enable),
    .cmd_done_o (cmd_done),
    .cmd_ack_o  (cmd_ack)
  );

  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    wel_cnt_d  = wel_cnt_q;
    poll_cnt_d = poll_cnt_q;
    err_code_d = err_code_q;
    issue      = 1'b0;
    issue_code = CMD_IDLE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wel_cnt_d  = '0;
          poll_cnt_d = '0;
          err_code_d = ERR_NONE;
          state_d    = op ? S_READ : S_WREN;
          issue      = 1'b1;
          issue_code = op ? CMD_RD_DATA : CMD_WRITE_CMD;
        end
      end
      S_WREN: begin
        if (cmd_done) begin
          next_d  = S_CHK_WEL;
          state_d = S_GAP;
        end
      end
      S_CHK_WEL: begin
        if (cmd_done) begin
          state_d = S_GAP;
          if (ctrl_status[STATUS_WEL_BIT]) begin
            next_d = S_PROG;
          end else begin
            wel_cnt_d = wel_inc;
            if (wel_inc == WEL_LIMIT) begin
              next_d     = S_ERR;
              err_code_d = ERR_WEL;
            end else begin
              next_d = S_CHK_WEL;
            end
          end
        end
      end
      S_PROG: begin
        if (cmd_done) begin
          next_d  = S_POLL;
          state_d = S_GAP;
        end
      end
      S_POLL: begin
        if (cmd_done) begin
          state_d = S_GAP;
          if (!ctrl_status[STATUS_WIP_BIT]) begin
            next_d = S_DONE;
          end else begin
            poll_cnt_d = poll_inc;
            if (poll_inc == POLL_LIMIT) begin
              next_d     = S_ERR;
              err_code_d = ERR_TIMEOUT;
            end else begin
              next_d = S_POLL;
            end
          end
        end
      end
      S_READ: begin
        if (cmd_done) begin
          next_d  = S_DONE;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Every exit from a command state passes here, so done/err also trail the gap.
        if (cmd_ack) begin
          state_d    = next_q;
          issue_code = state_cmd(next_q);
          issue      = (issue_code != CMD_IDLE);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      next_q     <= S_IDLE;
      wel_cnt_q  <= '0;
      poll_cnt_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      wel_cnt_q  <= wel_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign err_code = err_code_q;

endmodule
